// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide sequencer: latency-counted MULT/DIV, MTHI/MTLO, busy.
// Optional MADD/MADDU accumulate (op 6/7) enabled by defining MDU_MADD_EN.
module mdu_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        req,
    output logic        busy,
    output logic        mdu_wait,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW   = $clog2(MAXL + 1);

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t        r_state;
    state_t        w_state_n;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_n;
    logic          r_busy;
    logic          w_busy_n;
    logic [31:0]   r_hi;
    logic [31:0]   w_hi_n;
    logic [31:0]   r_lo;
    logic [31:0]   w_lo_n;
    logic [63:0]   r_res;
    logic [63:0]   w_res_n;
    logic          r_nowr;
    logic          w_nowr_n;

    logic          w_acc;
    logic          w_multi;
    logic          w_isdiv;
    logic          w_sgn;
    logic [63:0]   w_ma;
    logic [63:0]   w_mb;
    logic [63:0]   w_prod;
    logic          w_a_neg;
    logic          w_b_neg;
    logic [31:0]   w_a_mag;
    logic [31:0]   w_b_mag;
    logic [31:0]   w_b_safe;
    logic [31:0]   w_q_mag;
    logic [31:0]   w_r_mag;
    logic [31:0]   w_q;
    logic [31:0]   w_r;
    logic [63:0]   w_res_calc;

    assign w_acc   = start & ~req & (r_state == S_IDLE);
    assign w_isdiv = (op[2:1] == 2'b01);
    // Even opcodes are the signed flavours of MULT, DIV and MADD.
    assign w_sgn   = ~op[0];

`ifdef MDU_MADD_EN
    assign w_multi = ~((op == OP_MTHI) | (op == OP_MTLO));
`else
    assign w_multi = ~op[2];
`endif

    assign w_ma   = {{32{w_sgn & rs[31]}}, rs};
    assign w_mb   = {{32{w_sgn & rt[31]}}, rt};
    assign w_prod = w_ma * w_mb;

    // Magnitude division keeps 0x80000000 / -1 well defined (wraps).
    assign w_a_neg  = w_sgn & rs[31];
    assign w_b_neg  = w_sgn & rt[31];
    assign w_a_mag  = w_a_neg ? -rs : rs;
    assign w_b_mag  = w_b_neg ? -rt : rt;
    assign w_b_safe = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag  = w_a_mag / w_b_safe;
    assign w_r_mag  = w_a_mag % w_b_safe;
    assign w_q      = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    assign w_r      = w_a_neg ? -w_r_mag : w_r_mag;

`ifdef MDU_MADD_EN
    logic [63:0] w_macc;
    assign w_macc     = {r_hi, r_lo} + w_prod;
    assign w_res_calc = w_isdiv ? {w_r, w_q} :
                        (op[2] ? w_macc : w_prod);
`else
    assign w_res_calc = w_isdiv ? {w_r, w_q} : w_prod;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_res   <= '0;
            r_nowr  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_busy  <= w_busy_n;
            r_hi    <= w_hi_n;
            r_lo    <= w_lo_n;
            r_res   <= w_res_n;
            r_nowr  <= w_nowr_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_busy_n  = r_busy;
        w_hi_n    = r_hi;
        w_lo_n    = r_lo;
        w_res_n   = r_res;
        w_nowr_n  = r_nowr;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc && w_multi) begin
                    w_state_n = S_RUN;
                    w_busy_n  = 1'b1;
                    w_res_n   = w_res_calc;
                    w_nowr_n  = w_isdiv & (rt == 32'd0);
                    w_cnt_n   = w_isdiv ? CW'(DIV_LAT) : CW'(MUL_LAT);
                end else if (w_acc && op == OP_MTHI) begin
                    w_hi_n = rs;
                end else if (w_acc && op == OP_MTLO) begin
                    w_lo_n = rs;
                end
            end
            S_RUN: begin
                if (r_cnt == CW'(1)) begin
                    w_state_n = S_IDLE;
                    w_busy_n  = 1'b0;
                    w_cnt_n   = '0;
                    if (!r_nowr) begin
                        w_hi_n = r_res[63:32];
                        w_lo_n = r_res[31:0];
                    end
                end else begin
                    w_cnt_n = r_cnt - CW'(1);
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    assign busy     = r_busy;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign mdu_wait = r_busy | (start & w_multi & ~req);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: latency, HI/LO results, cancel, reset abort.
// Define MDU_MADD_EN for both files to exercise the MADD path.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        req;
    logic        busy;
    logic        mdu_wait;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk = 0;
    int n_err = 0;

    mdu_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs       (rs),
        .rt       (rt),
        .req      (req),
        .busy     (busy),
        .mdu_wait (mdu_wait),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_mc(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] eh,
                          input logic [31:0] el);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        #1;
        chk({tag, ".wait"}, 64'(mdu_wait), 64'd1);
        tick();
        start = 1'b0;
        for (int i = 0; i < lat; i++) begin
            chk({tag, ".busy"}, 64'(busy), 64'd1);
            tick();
        end
        chk({tag, ".done"}, 64'(busy), 64'd0);
        chk({tag, ".hi"}, 64'(hi), 64'(eh));
        chk({tag, ".lo"}, 64'(lo), 64'(el));
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] a);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = 32'd0;
        #1;
        chk("mt.wait", 64'(mdu_wait), 64'd0);
        tick();
        start = 1'b0;
        chk("mt.busy", 64'(busy), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        rs    = 32'd0;
        rt    = 32'd0;
        req   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.wait", 64'(mdu_wait), 64'd0);
        chk("rst.hi", 64'(hi), 64'd0);
        chk("rst.lo", 64'(lo), 64'd0);
        tick();

        run_mc("mult", 3'd0, 32'hFFFFFFFE, 32'd3, 5,
               32'hFFFFFFFF, 32'hFFFFFFFA);
        run_mc("divu", 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        run_mc("div", 3'd2, 32'hFFFFFFF9, 32'd2, 10,
               32'hFFFFFFFF, 32'hFFFFFFFD);

        // Cancelled start must leave everything untouched.
        start = 1'b1;
        op    = 3'd0;
        rs    = 32'd9;
        rt    = 32'd9;
        req   = 1'b1;
        #1;
        chk("req.wait", 64'(mdu_wait), 64'd0);
        tick();
        start = 1'b0;
        req   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("req.busy", 64'(busy), 64'd0);
            tick();
        end
        chk("req.hi", 64'(hi), 64'hFFFFFFFF);
        chk("req.lo", 64'(lo), 64'hFFFFFFFD);

        mt(3'd4, 32'h1234);
        chk("mthi.hi", 64'(hi), 64'h1234);
        chk("mthi.lo", 64'(lo), 64'hFFFFFFFD);
        mt(3'd5, 32'h5678);
        chk("mtlo.hi", 64'(hi), 64'h1234);
        chk("mtlo.lo", 64'(lo), 64'h5678);

        run_mc("div0", 3'd2, 32'd5, 32'd0, 10, 32'h1234, 32'h5678);
        run_mc("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,
               32'hFFFFFFFE, 32'h00000001);
        run_mc("divovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10,
               32'd0, 32'h80000000);

        // Asynchronous reset two cycles into a DIV.
        start = 1'b1;
        op    = 3'd3;
        rs    = 32'd100;
        rt    = 32'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("arst.busy", 64'(busy), 64'd0);
        chk("arst.hi", 64'(hi), 64'd0);
        chk("arst.lo", 64'(lo), 64'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("arst.idle", 64'(busy), 64'd0);
            tick();
        end
        chk("arst.hi2", 64'(hi), 64'd0);
        chk("arst.lo2", 64'(lo), 64'd0);

        mt(3'd4, 32'd0);
        mt(3'd5, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
        run_mc("maddu", 3'd7, 32'd1, 32'd1, 5, 32'd1, 32'd0);
        run_mc("madd", 3'd6, 32'hFFFFFFFF, 32'd2, 5,
               32'd0, 32'hFFFFFFFE);
`else
        start = 1'b1;
        op    = 3'd7;
        rs    = 32'd1;
        rt    = 32'd1;
        #1;
        chk("maddu.wait", 64'(mdu_wait), 64'd0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("maddu.busy", 64'(busy), 64'd0);
            tick();
        end
        chk("maddu.hi", 64'(hi), 64'd0);
        chk("maddu.lo", 64'(lo), 64'hFFFFFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
